// File: rtl/kv_icache_tagctrl_if.sv
// Bus bundle between the instruction-cache tag controller and its neighbours:
// fetch request/response, line refill memory port, LRU stage hookup and flush.
interface kv_icache_tagctrl_if #(
   parameter int WAY_NUM    = 4,
   parameter int LINE_NUM   = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128
);
   localparam int INDEX_WIDTH = $clog2(LINE_NUM / WAY_NUM);

   // fetch request
   logic                   i_req_valid;
   logic                   o_req_ready;
   logic [ADDR_WIDTH-1:0]  i_req_addr;
   // fetch response
   logic                   o_resp_valid;
   logic [31:0]            o_resp_data;
   logic                   i_resp_ready;
   // line refill port
   logic                   o_mem_req_valid;
   logic                   i_mem_req_ready;
   logic [ADDR_WIDTH-1:0]  o_mem_req_addr;
   logic                   i_mem_resp_valid;
   logic [LINE_WIDTH-1:0]  i_mem_resp_data;
   // LRU stage
   logic                   o_lru_update;
   logic [WAY_NUM-1:0]     o_lru_valid_way;
   logic [WAY_NUM-1:0]     o_lru_hitway;
   logic [INDEX_WIDTH-1:0] o_lru_index;
   logic [WAY_NUM-1:0]     i_lru_killmask;
   // maintenance
   logic                   i_flush;

   // controller side
   modport slave (
      input  i_req_valid, i_req_addr, i_resp_ready, i_mem_req_ready,
             i_mem_resp_valid, i_mem_resp_data, i_lru_killmask, i_flush,
      output o_req_ready, o_resp_valid, o_resp_data, o_mem_req_valid,
             o_mem_req_addr, o_lru_update, o_lru_valid_way, o_lru_hitway,
             o_lru_index
   );

   // environment side (fetch unit, memory, LRU stage)
   modport master (
      output i_req_valid, i_req_addr, i_resp_ready, i_mem_req_ready,
             i_mem_resp_valid, i_mem_resp_data, i_lru_killmask, i_flush,
      input  o_req_ready, o_resp_valid, o_resp_data, o_mem_req_valid,
             o_mem_req_addr, o_lru_update, o_lru_valid_way, o_lru_hitway,
             o_lru_index
   );
endinterface

// File: rtl/kv_icache_tagctrl.sv
// Tag/data lookup and miss-refill controller for the set-associative,
// read-only instruction cache. One request in flight; whole-line refills.
module kv_icache_tagctrl #(
   parameter int WAY_NUM    = 4,
   parameter int LINE_NUM   = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128
) (
   input logic                i_clk,
   input logic                i_rst,
   kv_icache_tagctrl_if.slave bus
);
   localparam int SETS         = LINE_NUM / WAY_NUM;
   localparam int INDEX_WIDTH  = $clog2(SETS);
   localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
   localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int WAY_W        = $clog2(WAY_NUM);
   localparam int WORDS        = LINE_WIDTH / 32;
   localparam int WSEL_W       = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_RESP, S_FLUSH
   } state_t;

   // control state
   state_t                           state_q, state_d;
   logic [TAG_WIDTH-1:0]             tag_q, tag_d;
   logic [INDEX_WIDTH-1:0]           index_q, index_d;
   logic [WSEL_W-1:0]                wsel_q, wsel_d;
   logic [WAY_W-1:0]                 victim_q, victim_d;
   logic [31:0]                      resp_data_q, resp_data_d;
   logic                             flush_pending_q, flush_pending_d;
   logic [SETS-1:0][WAY_NUM-1:0]     valid_q, valid_d;

   // arrays and their read registers
   logic [TAG_WIDTH-1:0]             tag_mem   [WAY_NUM][SETS];
   logic [LINE_WIDTH-1:0]            data_mem  [WAY_NUM][SETS];
   logic [TAG_WIDTH-1:0]             rd_tag_q  [WAY_NUM];
   logic [LINE_WIDTH-1:0]            rd_data_q [WAY_NUM];

   // request address split
   logic [TAG_WIDTH-1:0]             req_tag;
   logic [INDEX_WIDTH-1:0]           req_index;
   logic [WSEL_W-1:0]                req_wsel;
   logic                             addr_lsb_unused;

   // lookup results and strobes
   logic [WAY_NUM-1:0]               hit_vec;
   logic                             hit;
   logic [WAY_W-1:0]                 hit_way;
   logic [WAY_NUM-1:0]               set_valid;
   logic [WAY_W-1:0]                 miss_victim;
   logic                             req_ready;
   logic                             rd_en;
   logic                             fill_en;
   logic                             lru_update;
   logic [WAY_NUM-1:0]               lru_hitway;

   assign req_tag         = bus.i_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
   assign req_index       = bus.i_req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign req_wsel        = bus.i_req_addr[2 +: WSEL_W];
   assign addr_lsb_unused = ^bus.i_req_addr[1:0];
   assign set_valid       = valid_q[index_q];

   // Pick one 32-bit word out of a line; single-word lines always yield word 0.
   function automatic logic [31:0] select_word(input logic [LINE_WIDTH-1:0] line,
                                               input logic [WSEL_W-1:0]     sel);
      logic [31:0] w;
      w = line[31:0];
      for (int k = 0; k < WORDS; k++) begin
         if (sel == WSEL_W'(k)) w = line[k*32 +: 32];
      end
      return w;
   endfunction

   // Tag compare in every valid way; the lowest hitting way wins.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         hit_vec[w] = set_valid[w] && (rd_tag_q[w] == tag_q);
      end
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         if (hit_vec[w]) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Victim: lowest invalid way, else lowest kill-mask bit, else the last way.
   always_comb begin
      miss_victim = WAY_W'(WAY_NUM - 1);
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         if (bus.i_lru_killmask[w]) miss_victim = WAY_W'(w);
      end
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         if (!set_valid[w]) miss_victim = WAY_W'(w);
      end
   end

   assign req_ready = (state_q == S_IDLE) && !flush_pending_q && !bus.i_flush && !i_rst;

   // Next-state logic for the lookup/refill sequence.
   // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d         = state_q;
      tag_d           = tag_q;
      index_d         = index_q;
      wsel_d          = wsel_q;
      victim_d        = victim_q;
      resp_data_d     = resp_data_q;
      flush_pending_d = flush_pending_q;
      valid_d         = valid_q;
      rd_en           = 1'b0;
      fill_en         = 1'b0;
      lru_update      = 1'b0;
      lru_hitway      = '0;

      // a flush arriving mid-request is remembered and run afterwards
      if (state_q != S_IDLE && bus.i_flush) flush_pending_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (bus.i_flush || flush_pending_q) begin
               state_d = S_FLUSH;
            end else if (bus.i_req_valid) begin
               tag_d   = req_tag;
               index_d = req_index;
               wsel_d  = req_wsel;
               rd_en   = 1'b1;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               lru_update  = 1'b1;
               lru_hitway  = {{(WAY_NUM-1){1'b0}}, 1'b1} << hit_way;
               resp_data_d = select_word(rd_data_q[hit_way], wsel_q);
               state_d     = S_RESP;
            end else begin
               victim_d = miss_victim;
               state_d  = S_MISS_REQ;
            end
         end
         S_MISS_REQ: begin
            if (bus.i_mem_req_ready) state_d = S_MISS_WAIT;
         end
         S_MISS_WAIT: begin
            if (bus.i_mem_resp_valid) begin
               fill_en                    = 1'b1;
               valid_d[index_q][victim_q] = 1'b1;
               lru_update                 = 1'b1;
               lru_hitway                 = {{(WAY_NUM-1){1'b0}}, 1'b1} << victim_q;
               resp_data_d                = select_word(bus.i_mem_resp_data, wsel_q);
               state_d                    = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.i_resp_ready) begin
               state_d = (flush_pending_q || bus.i_flush) ? S_FLUSH : S_IDLE;
            end
         end
         S_FLUSH: begin
            valid_d         = '0;
            flush_pending_d = 1'b0;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers with synchronous reset.
   // NOTE: state is written with <= only; the blocking '=' lives solely in the always_comb next-state logic.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q         <= S_IDLE;
         tag_q           <= '0;
         index_q         <= '0;
         wsel_q          <= '0;
         victim_q        <= '0;
         resp_data_q     <= '0;
         flush_pending_q <= 1'b0;
         valid_q         <= '0;
      end else begin
         state_q         <= state_d;
         tag_q           <= tag_d;
         index_q         <= index_d;
         wsel_q          <= wsel_d;
         victim_q        <= victim_d;
         resp_data_q     <= resp_data_d;
         flush_pending_q <= flush_pending_d;
         valid_q         <= valid_d;
      end
   end

   // Tag/data arrays: synchronous read on accept, write on refill.
   // NOTE: the arrays are deliberately not reset; stale contents are harmless because the valid bits gate every hit.
   always_ff @(posedge i_clk) begin
      if (rd_en) begin
         for (int w = 0; w < WAY_NUM; w++) begin
            rd_tag_q[w]  <= tag_mem[w][req_index];
            rd_data_q[w] <= data_mem[w][req_index];
         end
      end
      if (fill_en) begin
         tag_mem[victim_q][index_q]  <= tag_q;
         data_mem[victim_q][index_q] <= bus.i_mem_resp_data;
      end
   end

   assign bus.o_req_ready     = req_ready;
   assign bus.o_resp_valid    = (state_q == S_RESP);
   assign bus.o_resp_data     = resp_data_q;
   assign bus.o_mem_req_valid = (state_q == S_MISS_REQ);
   assign bus.o_mem_req_addr  = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
   assign bus.o_lru_update    = lru_update;
   assign bus.o_lru_valid_way = set_valid;
   assign bus.o_lru_hitway    = lru_hitway;
   assign bus.o_lru_index     = index_q;
endmodule

// File: tb/tb_kv_icache_tagctrl.sv
// Directed self-checking bench for kv_icache_tagctrl (default parameters).
module tb_kv_icache_tagctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   kv_icache_tagctrl_if bus ();

   kv_icache_tagctrl dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // What one complete transaction looked like from the outside.
   typedef struct {
      bit          done;
      bit          missed;
      bit          both;
      bit          ready_busy;
      int          upd_cnt;
      int          resp_cycle;
      logic [31:0] mem_addr;
      logic [31:0] data;
      logic [3:0]  hitway;
      logic [3:0]  index;
      logic [3:0]  valid_way;
   } obs_t;

   localparam logic [127:0] LINE_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

   function automatic logic [127:0] mk_line(input int k);
      return {32'(k*16+3), 32'(k*16+2), 32'(k*16+1), 32'(k*16)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Full request with memory and consumer always ready; the refill line is
   // returned in the cycle after the memory request is taken.
   task automatic txn(input logic [31:0] addr, input logic [127:0] line, output obs_t o);
      bit give_line;
      bit accepted;
      int wait_cyc;
      o = '{default: 0};
      give_line = 1'b0;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = addr;
      wait_cyc = 0;
      @(negedge clk);
      while (!bus.o_req_ready && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      accepted = bus.o_req_ready;
      step();
      bus.i_req_valid = 1'b0;
      if (!accepted) return;
      for (int cyc = 1; cyc <= 40 && !o.done; cyc++) begin
         @(negedge clk);
         if (bus.o_req_ready) o.ready_busy = 1'b1;
         if (bus.o_lru_update) begin
            o.upd_cnt++;
            o.hitway    = bus.o_lru_hitway;
            o.index     = bus.o_lru_index;
            o.valid_way = bus.o_lru_valid_way;
         end
         if (bus.o_mem_req_valid) begin
            o.missed   = 1'b1;
            o.mem_addr = bus.o_mem_req_addr;
            give_line  = bus.i_mem_req_ready;
         end
         if (bus.o_mem_req_valid && bus.o_resp_valid) o.both = 1'b1;
         if (bus.o_resp_valid) begin
            o.done       = 1'b1;
            o.resp_cycle = cyc;
            o.data       = bus.o_resp_data;
         end
         step();
         bus.i_mem_resp_valid = 1'b0;
         if (give_line) begin
            bus.i_mem_resp_valid = 1'b1;
            bus.i_mem_resp_data  = line;
            give_line = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      @(negedge clk);
      n_checks++;
      if (bus.o_req_ready !== 1'b0) $display("FAIL reset_ready_in_reset got=%b exp=0", bus.o_req_ready);
      else n_pass++;
      step();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.o_req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.o_req_ready);
      else n_pass++;
      n_checks++;
      if ({bus.o_resp_valid, bus.o_mem_req_valid, bus.o_lru_update} !== 3'b000)
         $display("FAIL reset_valids got=%b exp=000", {bus.o_resp_valid, bus.o_mem_req_valid, bus.o_lru_update});
      else n_pass++;
      n_checks++;
      if ({bus.o_lru_valid_way, bus.o_lru_hitway, bus.o_lru_index, bus.o_resp_data, bus.o_mem_req_addr} !== '0)
         $display("FAIL reset_outputs_zero got vw=%b hw=%b idx=%h data=%h maddr=%h exp all 0",
                  bus.o_lru_valid_way, bus.o_lru_hitway, bus.o_lru_index, bus.o_resp_data, bus.o_mem_req_addr);
      else n_pass++;
      step();
   endtask

   task automatic test_miss_then_hit();
      obs_t o;
      txn(32'h0000_1004, LINE_A, o);
      n_checks++;
      if (!(o.missed && o.mem_addr === 32'h0000_1000))
         $display("FAIL miss_mem_addr got missed=%b addr=%h exp missed=1 addr=00001000", o.missed, o.mem_addr);
      else n_pass++;
      n_checks++;
      if (o.data !== 32'hBBBBBBBB) $display("FAIL miss_data got=%h exp=bbbbbbbb", o.data);
      else n_pass++;
      n_checks++;
      if (o.hitway !== 4'b0001 || o.index !== 4'd0 || o.upd_cnt != 1)
         $display("FAIL miss_lru got hw=%b idx=%0d upd=%0d exp hw=0001 idx=0 upd=1", o.hitway, o.index, o.upd_cnt);
      else n_pass++;
      n_checks++;
      if (o.resp_cycle != 4) $display("FAIL miss_latency got=%0d exp=4", o.resp_cycle);
      else n_pass++;

      txn(32'h0000_1004, LINE_A, o);
      n_checks++;
      if (o.missed || o.resp_cycle != 2)
         $display("FAIL hit_latency got missed=%b cyc=%0d exp missed=0 cyc=2", o.missed, o.resp_cycle);
      else n_pass++;
      n_checks++;
      if (o.data !== 32'hBBBBBBBB || o.hitway !== 4'b0001 || o.upd_cnt != 1)
         $display("FAIL hit_result got data=%h hw=%b upd=%0d exp data=bbbbbbbb hw=0001 upd=1", o.data, o.hitway, o.upd_cnt);
      else n_pass++;
   endtask

   task automatic test_replacement();
      obs_t o;
      do_reset();
      bus.i_lru_killmask = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         txn(32'(k * 'h100), mk_line(k), o);
         n_checks++;
         if (!o.missed || o.hitway !== 4'(1 << k) || o.data !== 32'(k*16))
            $display("FAIL fill_way%0d got missed=%b hw=%b data=%h exp missed=1 hw=%b data=%h",
                     k, o.missed, o.hitway, o.data, 4'(1 << k), 32'(k*16));
         else n_pass++;
      end
      bus.i_lru_killmask = 4'b0100;
      txn(32'h400, mk_line(4), o);
      n_checks++;
      if (!o.missed || o.hitway !== 4'b0100 || o.mem_addr !== 32'h400)
         $display("FAIL kill_victim got missed=%b hw=%b addr=%h exp missed=1 hw=0100 addr=00000400", o.missed, o.hitway, o.mem_addr);
      else n_pass++;
      txn(32'h200, mk_line(2), o);
      n_checks++;
      if (!o.missed || o.data !== 32'h20)
         $display("FAIL evicted_misses got missed=%b data=%h exp missed=1 data=00000020", o.missed, o.data);
      else n_pass++;
      txn(32'h300, mk_line(3), o);
      n_checks++;
      if (o.missed || o.hitway !== 4'b1000 || o.data !== 32'h30 || o.valid_way !== 4'b1111)
         $display("FAIL way3_hit got missed=%b hw=%b data=%h vw=%b exp missed=0 hw=1000 data=00000030 vw=1111",
                  o.missed, o.hitway, o.data, o.valid_way);
      else n_pass++;
      bus.i_lru_killmask = 4'b0000;
      txn(32'h500, mk_line(5), o);
      n_checks++;
      if (!o.missed || o.hitway !== 4'b1000) $display("FAIL zero_kill_victim got hw=%b exp=1000", o.hitway);
      else n_pass++;
      bus.i_lru_killmask = 4'b1010;
      txn(32'h600, mk_line(6), o);
      n_checks++;
      if (!o.missed || o.hitway !== 4'b0010) $display("FAIL lowest_kill_victim got hw=%b exp=0010", o.hitway);
      else n_pass++;
      bus.i_lru_killmask = 4'b0000;
   endtask

   task automatic test_stall();
      int bad_req;
      int bad_resp;
      bad_req  = 0;
      bad_resp = 0;
      bus.i_mem_req_ready = 1'b0;
      bus.i_resp_ready    = 1'b0;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h0000_2018;
      step();                    // accepted -> LOOKUP
      bus.i_req_valid = 1'b0;
      step();                    // MISS_REQ
      repeat (3) begin
         @(negedge clk);
         if (bus.o_mem_req_valid !== 1'b1 || bus.o_mem_req_addr !== 32'h0000_2010 || bus.o_resp_valid !== 1'b0)
            bad_req++;
         step();
      end
      bus.i_mem_req_ready = 1'b1;
      @(negedge clk);
      if (bus.o_mem_req_valid !== 1'b1 || bus.o_mem_req_addr !== 32'h0000_2010) bad_req++;
      n_checks++;
      if (bad_req != 0) $display("FAIL mem_req_stable got %0d bad cycles exp 0", bad_req);
      else n_pass++;
      step();                    // MISS_WAIT
      bus.i_mem_resp_valid = 1'b1;
      bus.i_mem_resp_data  = mk_line(7);
      @(negedge clk);
      n_checks++;
      if (bus.o_lru_update !== 1'b1 || bus.o_lru_hitway !== 4'b0001 || bus.o_lru_index !== 4'd1)
         $display("FAIL stall_refill_lru got upd=%b hw=%b idx=%0d exp upd=1 hw=0001 idx=1",
                  bus.o_lru_update, bus.o_lru_hitway, bus.o_lru_index);
      else n_pass++;
      step();                    // RESP
      bus.i_mem_resp_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.o_resp_valid !== 1'b1 || bus.o_resp_data !== 32'h72 || bus.o_req_ready !== 1'b0 ||
             bus.o_lru_update !== 1'b0)
            bad_resp++;
         step();
      end
      n_checks++;
      if (bad_resp != 0) $display("FAIL resp_stable got %0d bad cycles exp 0", bad_resp);
      else n_pass++;
      bus.i_resp_ready = 1'b1;
      step();                    // IDLE
      @(negedge clk);
      n_checks++;
      if (bus.o_resp_valid !== 1'b0 || bus.o_req_ready !== 1'b1)
         $display("FAIL stall_release got rv=%b rdy=%b exp rv=0 rdy=1", bus.o_resp_valid, bus.o_req_ready);
      else n_pass++;
      step();
   endtask

   task automatic test_flush_midflight();
      obs_t o;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h0000_3024;
      step();                    // LOOKUP
      bus.i_req_valid = 1'b0;
      step();                    // MISS_REQ
      step();                    // MISS_WAIT
      bus.i_flush = 1'b1;
      step();
      bus.i_flush = 1'b0;
      bus.i_mem_resp_valid = 1'b1;
      bus.i_mem_resp_data  = mk_line(8);
      step();                    // RESP
      bus.i_mem_resp_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.o_resp_valid !== 1'b1 || bus.o_resp_data !== 32'h81)
         $display("FAIL flush_resp got rv=%b data=%h exp rv=1 data=00000081", bus.o_resp_valid, bus.o_resp_data);
      else n_pass++;
      step();                    // FLUSH
      @(negedge clk);
      n_checks++;
      if (bus.o_req_ready !== 1'b0 || bus.o_resp_valid !== 1'b0)
         $display("FAIL flush_cycle got rdy=%b rv=%b exp rdy=0 rv=0", bus.o_req_ready, bus.o_resp_valid);
      else n_pass++;
      step();                    // IDLE
      @(negedge clk);
      n_checks++;
      if (bus.o_req_ready !== 1'b1) $display("FAIL post_flush_ready got=%b exp=1", bus.o_req_ready);
      else n_pass++;
      step();
      txn(32'h0000_3024, mk_line(8), o);
      n_checks++;
      if (!o.missed || o.data !== 32'h81 || o.hitway !== 4'b0001)
         $display("FAIL flushed_line_misses got missed=%b data=%h hw=%b exp missed=1 data=00000081 hw=0001",
                  o.missed, o.data, o.hitway);
      else n_pass++;
   endtask

   task automatic test_reset_midflight();
      obs_t o;
      int bad;
      bad = 0;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h0000_4038;
      step();                    // LOOKUP
      bus.i_req_valid = 1'b0;
      step();                    // MISS_REQ
      step();                    // MISS_WAIT
      rst = 1'b1;
      step();                    // IDLE
      rst = 1'b0;
      bus.i_mem_resp_valid = 1'b1;
      bus.i_mem_resp_data  = mk_line(9);
      @(negedge clk);
      if (bus.o_resp_valid !== 1'b0 || bus.o_lru_update !== 1'b0) bad++;
      step();
      bus.i_mem_resp_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (bus.o_resp_valid !== 1'b0 || bus.o_lru_update !== 1'b0) bad++;
         step();
      end
      n_checks++;
      if (bad != 0) $display("FAIL stale_refill_ignored got %0d bad cycles exp 0", bad);
      else n_pass++;
      txn(32'h0000_4038, mk_line(9), o);
      n_checks++;
      if (!o.missed || o.data !== 32'h92)
         $display("FAIL reset_line_misses got missed=%b data=%h exp missed=1 data=00000092", o.missed, o.data);
      else n_pass++;
   endtask

   task automatic test_req_with_flush();
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h0000_5054;
      bus.i_flush     = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.o_req_ready !== 1'b0) $display("FAIL req_flush_same_cycle got rdy=%b exp=0", bus.o_req_ready);
      else n_pass++;
      step();                    // FLUSH
      bus.i_flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.o_req_ready !== 1'b0) $display("FAIL req_flush_flush_cycle got rdy=%b exp=0", bus.o_req_ready);
      else n_pass++;
      step();                    // IDLE, request accepted at the next edge
      @(negedge clk);
      n_checks++;
      if (bus.o_req_ready !== 1'b1) $display("FAIL req_flush_accept got rdy=%b exp=1", bus.o_req_ready);
      else n_pass++;
      step();                    // LOOKUP
      bus.i_req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.o_lru_index !== 4'd5 || bus.o_req_ready !== 1'b0)
         $display("FAIL req_flush_lookup got idx=%0d rdy=%b exp idx=5 rdy=0", bus.o_lru_index, bus.o_req_ready);
      else n_pass++;
      step();                    // MISS_REQ
      @(negedge clk);
      n_checks++;
      if (bus.o_mem_req_valid !== 1'b1 || bus.o_mem_req_addr !== 32'h0000_5050)
         $display("FAIL req_flush_memreq got v=%b addr=%h exp v=1 addr=00005050", bus.o_mem_req_valid, bus.o_mem_req_addr);
      else n_pass++;
      step();                    // MISS_WAIT
      bus.i_mem_resp_valid = 1'b1;
      bus.i_mem_resp_data  = mk_line(10);
      step();                    // RESP
      bus.i_mem_resp_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.o_resp_valid !== 1'b1 || bus.o_resp_data !== 32'hA1)
         $display("FAIL req_flush_resp got rv=%b data=%h exp rv=1 data=000000a1", bus.o_resp_valid, bus.o_resp_data);
      else n_pass++;
      step();                    // IDLE
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst                  = 1'b1;
      bus.i_req_valid      = 1'b0;
      bus.i_req_addr       = '0;
      bus.i_resp_ready     = 1'b1;
      bus.i_mem_req_ready  = 1'b1;
      bus.i_mem_resp_valid = 1'b0;
      bus.i_mem_resp_data  = '0;
      bus.i_lru_killmask   = '0;
      bus.i_flush          = 1'b0;

      test_reset();
      test_miss_then_hit();
      test_replacement();
      test_stall();
      test_flush_midflight();
      test_reset_midflight();
      test_req_with_flush();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
